// File: rtl/rs_dsp_pkg.sv
// Shared constants, stage-1 operand record and the behavioural DSP38 multiply
// used by rs_dsp_mult_arbiter.
package rs_dsp_pkg;

  localparam int A_W        = 20;
  localparam int B_W        = 18;
  localparam int Z_W        = 38;
  localparam int PERF_CNT_W = 16;
  localparam int MAX_ID_W   = 3;
  localparam logic [2:0] FB_MULT = 3'b000;

  typedef struct packed {
    logic [A_W-1:0]      a;
    logic [B_W-1:0]      b;
    logic                ua;
    logic                ub;
    logic [MAX_ID_W-1:0] id;
    logic                valid;
  } s1_op_t;

  // DSP38 in MULTIPLY mode, combinational. Only the no-feedback path exists here.
  function automatic logic [Z_W-1:0] dsp38_z(input logic [2:0]     fb,
                                             input logic [A_W-1:0] a,
                                             input logic [B_W-1:0] b,
                                             input logic           ua,
                                             input logic           ub);
    logic [Z_W-1:0] ax;
    logic [Z_W-1:0] bx;
    ax = ua ? Z_W'(a) : {{(Z_W-A_W){a[A_W-1]}}, a};
    bx = ub ? Z_W'(b) : {{(Z_W-B_W){b[B_W-1]}}, b};
    if (fb != FB_MULT) begin
      return '0;
    end
    return ax * bx;
  endfunction

endpackage

// File: rtl/rs_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// moves the pointer past the winner whenever the grant is taken.
module rs_rr_arbiter
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rs_dsp_mult_arbiter.sv
// One DSP38 multiplier shared by NUM_REQ requesters: round-robin grant, operand
// register, registered product. Optional counters: RS_DSP_MULT_ARB_PERF_EN.
// Handshakes: a beat moves when valid & ready are both high at a rising edge;
// valid never depends on ready, and the producer holds data until accepted.
module rs_dsp_mult_arbiter
  import rs_dsp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]     req_unsigned_a,
  input  logic [NUM_REQ-1:0]     req_unsigned_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [Z_W-1:0]         rsp_z,
  output logic [ID_W-1:0]        rsp_id
`ifdef RS_DSP_MULT_ARB_PERF_EN
  ,
  input  logic                          perf_clr,
  output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grant_cnt,
  output logic [PERF_CNT_W-1:0]         perf_stall_cnt
`endif
);

  logic               s2_stall;
  logic               s1_free;
  logic               xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [Z_W-1:0]     dsp_z;

  s1_op_t          s1_q, s1_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [Z_W-1:0]  rsp_z_q, rsp_z_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  assign s2_stall = rsp_valid_q & ~rsp_ready;
  assign s1_free  = ~s1_q.valid | ~s2_stall;

  // rst_n in the enable keeps req_ready low for the whole reset window.
  rs_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (s1_free & rst_n),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);

  always_comb begin
    s1_d = s1_q;
    if (xfer) begin
      s1_d.valid = 1'b1;
      s1_d.id    = MAX_ID_W'(gnt_idx);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          s1_d.a  = req_a[i*A_W +: A_W];
          s1_d.b  = req_b[i*B_W +: B_W];
          s1_d.ua = req_unsigned_a[i];
          s1_d.ub = req_unsigned_b[i];
        end
      end
    end else if (!s2_stall) begin
      s1_d.valid = 1'b0;
    end
  end

  assign dsp_z = dsp38_z(FB_MULT, s1_q.a, s1_q.b, s1_q.ua, s1_q.ub);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_id_d    = rsp_id_q;
    if (!s2_stall) begin
      rsp_valid_d = s1_q.valid;
      rsp_z_d     = dsp_z;
      rsp_id_d    = s1_q.id[ID_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = rsp_id_q;

`ifdef RS_DSP_MULT_ARB_PERF_EN
  logic [NUM_REQ*PERF_CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [PERF_CNT_W-1:0]         stall_cnt_q, stall_cnt_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (perf_clr) begin
      grant_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && gnt[i] && (grant_cnt_q[i*PERF_CNT_W +: PERF_CNT_W] != '1)) begin
          grant_cnt_d[i*PERF_CNT_W +: PERF_CNT_W] =
            grant_cnt_q[i*PERF_CNT_W +: PERF_CNT_W] + PERF_CNT_W'(1);
        end
      end
      if (s2_stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_grant_cnt = grant_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rs_dsp_mult_arbiter.sv
// Directed self-checking bench for rs_dsp_mult_arbiter: hand-computed products
// and grant orders plus a scoreboard of expected responses.
module tb_rs_dsp_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 20;
  localparam int B_W     = 18;
  localparam int Z_W     = 38;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     req_unsigned_a;
  logic [NUM_REQ-1:0]     req_unsigned_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [Z_W-1:0]         rsp_z;
  logic [ID_W-1:0]        rsp_id;
`ifdef RS_DSP_MULT_ARB_PERF_EN
  logic                   perf_clr;
  logic [NUM_REQ*16-1:0]  perf_grant_cnt;
  logic [15:0]            perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [ID_W+Z_W-1:0] exp_q[$];
  logic [ID_W+Z_W-1:0] sb_e;

  // Hand-computed products for the four streaming operand sets.
  logic [Z_W-1:0] zt[4];
  int             g_list[12];
  logic [3:0]     bp_rdy[6];
  logic [3:0]     exp_rdy;

  rs_dsp_mult_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_unsigned_a (req_unsigned_a),
    .req_unsigned_b (req_unsigned_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_z          (rsp_z),
    .rsp_id         (rsp_id)
`ifdef RS_DSP_MULT_ARB_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver
  task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic ua, input logic ub);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
    req_unsigned_a[i]   = ua;
    req_unsigned_b[i]   = ub;
  endtask

  function automatic logic [Z_W-1:0] model_z(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                             input logic ua, input logic ub);
    longint      sa;
    longint      sb;
    longint      p;
    logic [63:0] pb;
    if (ua) sa = longint'({44'd0, a});
    else    sa = longint'($signed(a));
    if (ub) sb = longint'({46'd0, b});
    else    sb = longint'($signed(b));
    p  = sa * sb;
    pb = p;
    return pb[Z_W-1:0];
  endfunction

  // Scoreboard: inputs only change just after a rising edge, so the falling
  // edge sees exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        check_eq("sb_rsp_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          sb_e = exp_q.pop_front();
          check_eq("sb_id", 64'(rsp_id), 64'(sb_e[ID_W+Z_W-1:Z_W]));
          check_eq("sb_z", 64'(rsp_z), 64'(sb_e[Z_W-1:0]));
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({ID_W'(i), model_z(req_a[i*A_W +: A_W], req_b[i*B_W +: B_W],
                                             req_unsigned_a[i], req_unsigned_b[i])});
        end
      end
    end
  end

  initial begin
    zt[0] = 38'h01E6BD5541;
    zt[1] = 38'h0FFFF60001;
    zt[2] = 38'h3FFFF80000;
    zt[3] = 38'h1000000000;
    g_list = '{2, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    bp_rdy = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000};

    rst_n          = 1'b0;
    req_valid      = '0;
    req_a          = '0;
    req_b          = '0;
    req_unsigned_a = '0;
    req_unsigned_b = '0;
    rsp_ready      = 1'b1;
`ifdef RS_DSP_MULT_ARB_PERF_EN
    perf_clr       = 1'b0;
`endif

    // Reset state, with every requester asking
    set_op(0, 20'hFFFFD, 18'd5, 1'b0, 1'b0);
    req_valid = 4'hF;
    repeat (3) step();
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_z", 64'(rsp_z), 64'd0);
    check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    step();

    // Signed multiply: -3 * 5, two-cycle latency
    req_valid = 4'b0001;
    #1;
    check_eq("t1_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    #1;
    check_eq("t1_lat_cycle1", 64'(rsp_valid), 64'd0);
    step();
    check_eq("t1_lat_cycle2", 64'(rsp_valid), 64'd1);
    check_eq("t1_z", 64'(rsp_z), 64'h3F_FFFF_FFF1);
    check_eq("t1_id", 64'(rsp_id), 64'd0);
    step();
    check_eq("t1_drained", 64'(rsp_valid), 64'd0);

    // Unsigned A: same operands, pointer at 1 wraps back to requester 0
    set_op(0, 20'hFFFFD, 18'd5, 1'b1, 1'b0);
    req_valid = 4'b0001;
    #1;
    check_eq("t2_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    step();
    check_eq("t2_valid", 64'(rsp_valid), 64'd1);
    check_eq("t2_z", 64'(rsp_z), 64'h00_004F_FFF1);
    step();

    // Sparse req 2 twice (pointer ends at 3), then all four round-robin
    set_op(0, 20'h12345, 18'h1ABCD, 1'b1, 1'b1);
    set_op(1, 20'h7FFFF, 18'h1FFFF, 1'b0, 1'b0);
    set_op(2, 20'h80000, 18'h00001, 1'b0, 1'b0);
    set_op(3, 20'h80000, 18'h20000, 1'b0, 1'b0);
    for (int n = 0; n < 12; n++) begin
      req_valid = (n < 2) ? 4'b0100 : 4'b1111;
      #1;
      exp_rdy = 4'(1 << g_list[n]);
      check_eq("rr_grant", 64'(req_ready), 64'(exp_rdy));
      if (n >= 2) begin
        check_eq("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("rr_rsp_id", 64'(rsp_id), 64'(g_list[n-2]));
        check_eq("rr_rsp_z", 64'(rsp_z), 64'(zt[g_list[n-2]]));
      end else begin
        check_eq("rr_rsp_idle", 64'(rsp_valid), 64'd0);
      end
      step();
    end
    req_valid = '0;
    repeat (3) step();

    // Backpressure from an empty pipe: two accepts, then everything stalls
    for (int n = 0; n < 6; n++) begin
      req_valid = 4'hF;
      rsp_ready = (n == 5);
      #1;
      check_eq("bp_ready", 64'(req_ready), 64'(bp_rdy[n]));
      if (n >= 2) begin
        check_eq("bp_hold_valid", 64'(rsp_valid), 64'd1);
        check_eq("bp_hold_id", 64'(rsp_id), 64'd1);
        check_eq("bp_hold_z", 64'(rsp_z), 64'(zt[1]));
      end
      step();
    end
    req_valid = '0;
    #1;
    check_eq("bp_drain_id2", 64'(rsp_id), 64'd2);
    step();
    check_eq("bp_drain_id3", 64'(rsp_id), 64'd3);
    step();
    check_eq("bp_drain_done", 64'(rsp_valid), 64'd0);

    // Reset with both stages full
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    step();
    step();
    #1;
    check_eq("rf_full_valid", 64'(rsp_valid), 64'd1);
    check_eq("rf_full_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rf_async_valid", 64'(rsp_valid), 64'd0);
    check_eq("rf_async_ready", 64'(req_ready), 64'd0);
    step();
    req_valid = '0;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      check_eq("rf_no_stale", 64'(rsp_valid), 64'd0);
    end
    req_valid = 4'hF;
    #1;
    check_eq("rf_first_grant", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    repeat (3) step();
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
